// File: rtl/automata_window_buffer.sv
// -----------------------------------------------------------------------------
// automata_window_buffer
//
// Takes one cellular-automaton row as CHUNKS_PER_ROW chunks of CHUNK_W cells.
// For each chunk it emits one window made of the chunk plus HALO neighbour
// cells on each side. Halo cells that fall outside the row edges are filled
// with PAD_VAL. The window for chunk j can only be built once chunk j+1 has
// arrived, because its right halo comes from that chunk. The window for the
// final chunk is therefore produced internally in the DRAIN state.
//
// Ports
//   clk        rising-edge clock
//   clear      asynchronous active-high reset
//   flush      synchronous abort of the current row (wins over handshakes)
//   in_valid   in_data is valid
//   in_ready   the buffer accepts in_data this cycle
//   in_data    one chunk; the MSB is the earliest (left-most) cell
//   out_valid  out_data and the flags are valid
//   out_ready  the consumer takes the window
//   out_data   {left halo, centre chunk, right halo}, MSB first
//   out_first  the window is chunk 0 of the row
//   out_last   the window is chunk CHUNKS_PER_ROW-1 of the row
// -----------------------------------------------------------------------------
module automata_window_buffer #(
    parameter int   CHUNK_W        = 20,
    parameter int   HALO           = 1,
    parameter int   CHUNKS_PER_ROW = 32,
    parameter logic PAD_VAL        = 1'b0
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHUNK_W-1:0]        in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHUNK_W+2*HALO-1:0] out_data,
    output logic                      out_first,
    output logic                      out_last
);

    localparam int               COL_W    = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHUNKS_PER_ROW - 1);
    localparam logic [HALO-1:0]  PAD_HALO = {HALO{PAD_VAL}};
    localparam bit               SINGLE   = (CHUNKS_PER_ROW == 1);

    typedef enum logic [1:0] {EMPTY, HOLD, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [COL_W-1:0]   col;
    logic [CHUNK_W-1:0] hold;   // centre chunk whose window still lacks a right halo
    logic [HALO-1:0]    lh;     // left halo for the window of hold
    logic               free;
    logic               in_acc;
    logic               out_acc;

    // The output register can take a new window when it is empty or is
    // being emptied this cycle.
    assign free    = !out_valid || out_ready;
    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;

    always_comb begin
        in_ready  = 1'b0;
        state_nxt = state;
        case (state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_acc) state_nxt = SINGLE ? DRAIN : HOLD;
            end
            HOLD: begin
                in_ready = free;
                if (in_acc && (col == LAST_COL)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (free) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= EMPTY;
            col       <= '0;
            hold      <= '0;
            lh        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (flush) begin
            // Abort the row: any handshake seen in this cycle is discarded.
            state     <= EMPTY;
            col       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (out_acc) out_valid <= 1'b0;
            case (state)
                EMPTY: begin
                    // Chunk 0 only primes the buffer; its window needs chunk 1.
                    if (in_acc) begin
                        hold <= in_data;
                        lh   <= PAD_HALO;
                        col  <= COL_W'(1);
                    end
                end
                HOLD: begin
                    if (in_acc) begin
                        out_data  <= {lh, hold, in_data[CHUNK_W-1 -: HALO]};
                        out_valid <= 1'b1;
                        out_first <= (col == COL_W'(1));
                        out_last  <= 1'b0;
                        lh        <= hold[HALO-1:0];
                        hold      <= in_data;
                        if (col != LAST_COL) col <= col + COL_W'(1);
                    end
                end
                DRAIN: begin
                    // The last chunk has no successor; its right halo is padding.
                    if (free) begin
                        out_data  <= {lh, hold, PAD_HALO};
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_first <= SINGLE;
                        col       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_automata_window_buffer.sv
module tb_automata_window_buffer;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       out_ready = 1'b1;

    logic       ir0, ov0, of0, ol0;
    logic [5:0] od0;
    logic       ir1, ov1, of1, ol1;
    logic [5:0] od1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    automata_window_buffer #(.CHUNK_W(4), .HALO(1), .CHUNKS_PER_ROW(3), .PAD_VAL(1'b0)) dut0 (
        .clk(clk), .clear(clear), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_first(of0), .out_last(ol0)
    );

    automata_window_buffer #(.CHUNK_W(4), .HALO(1), .CHUNKS_PER_ROW(3), .PAD_VAL(1'b1)) dut1 (
        .clk(clk), .clear(clear), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_first(of1), .out_last(ol1)
    );

    localparam logic [3:0] A = 4'b1001;
    localparam logic [3:0] B = 4'b0110;
    localparam logic [3:0] C = 4'b1111;

    // Stream driver state
    logic [3:0] src [8];
    int         nsrc;
    int         stall_req;
    bit         sel;            // 0: record dut0, 1: record dut1
    logic [5:0] wd [$];
    bit         wf [$];
    bit         wl [$];
    logic [5:0] st_data [$];
    logic       st_inrdy [$];
    int         bubbles;

    // Feeds src[0..nsrc-1] and collects up to 'want' accepted windows.
    // Inputs change on the falling edge; outputs are observed 1ns later.
    task automatic run(input int want, input int maxc);
        int idx = 0;
        int sc = 0;
        logic       v, f, l;
        logic [5:0] d;
        wd.delete(); wf.delete(); wl.delete();
        st_data.delete(); st_inrdy.delete();
        bubbles = 0;
        for (int c = 0; c < maxc && wd.size() < want; c++) begin
            @(negedge clk);
            in_valid = (idx < nsrc);
            in_data  = (idx < nsrc) ? src[idx] : 4'd0;
            v = sel ? ov1 : ov0;
            if (sc < stall_req && v && wd.size() == 0) begin
                out_ready = 1'b0;
                sc++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            v = sel ? ov1 : ov0;
            d = sel ? od1 : od0;
            f = sel ? of1 : of0;
            l = sel ? ol1 : ol0;
            if (!out_ready) begin
                st_data.push_back(d);
                st_inrdy.push_back(ir0);
            end
            if (v && out_ready) begin
                wd.push_back(d);
                wf.push_back(f);
                wl.push_back(l);
            end
            if (in_valid) begin
                if (ir0) idx++;
                else bubbles++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic load_row(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        src[0] = a; src[1] = b; src[2] = c;
        nsrc = 3;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
        checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir0); end
        checks++; if (od0 !== 6'd0) begin failures++; $display("FAIL reset_out_data got=%b exp=000000", od0); end
        checks++; if ({of0, ol0} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {of0, ol0}); end
        checks++; if (ir1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_pad1 got=%b exp=1", ir1); end
    endtask

    task automatic test_basic_row;
        logic [5:0] exp_d [3] = '{6'b010010, 6'b101101, 6'b011110};
        bit         exp_f [3] = '{1'b1, 1'b0, 1'b0};
        bit         exp_l [3] = '{1'b0, 1'b0, 1'b1};
        sel = 1'b0; stall_req = 0;
        load_row(A, B, C);
        run(3, 40);
        checks++; if (wd.size() !== 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", wd.size()); end
        for (int i = 0; i < 3 && i < wd.size(); i++) begin
            checks++; if (wd[i] !== exp_d[i]) begin failures++; $display("FAIL basic_data[%0d] got=%b exp=%b", i, wd[i], exp_d[i]); end
            checks++; if ({wf[i], wl[i]} !== {exp_f[i], exp_l[i]}) begin failures++; $display("FAIL basic_flags[%0d] got=%b exp=%b", i, {wf[i], wl[i]}, {exp_f[i], exp_l[i]}); end
        end
        #1;
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL basic_idle_valid got=%b exp=0", ov0); end
    endtask

    task automatic test_backpressure;
        logic [5:0] exp_d [3] = '{6'b010010, 6'b101101, 6'b011110};
        sel = 1'b0; stall_req = 5;
        load_row(A, B, C);
        run(3, 40);
        stall_req = 0;
        checks++; if (st_data.size() !== 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", st_data.size()); end
        for (int i = 0; i < st_data.size(); i++) begin
            checks++; if (st_data[i] !== 6'b010010) begin failures++; $display("FAIL stall_hold[%0d] got=%b exp=010010", i, st_data[i]); end
            checks++; if (st_inrdy[i] !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, st_inrdy[i]); end
        end
        checks++; if (wd.size() !== 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", wd.size()); end
        for (int i = 0; i < 3 && i < wd.size(); i++) begin
            checks++; if (wd[i] !== exp_d[i]) begin failures++; $display("FAIL stall_data[%0d] got=%b exp=%b", i, wd[i], exp_d[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp_d [6] = '{6'b010010, 6'b101101, 6'b011110, 6'b010010, 6'b101101, 6'b011110};
        bit         exp_f [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit         exp_l [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        sel = 1'b0; stall_req = 0;
        src[0] = A; src[1] = B; src[2] = C; src[3] = A; src[4] = B; src[5] = C;
        nsrc = 6;
        run(6, 60);
        checks++; if (wd.size() !== 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", wd.size()); end
        // Only the first row's drain happens while more input is waiting.
        checks++; if (bubbles !== 1) begin failures++; $display("FAIL b2b_bubbles got=%0d exp=1", bubbles); end
        for (int i = 0; i < 6 && i < wd.size(); i++) begin
            checks++; if ({wd[i], wf[i], wl[i]} !== {exp_d[i], exp_f[i], exp_l[i]}) begin
                failures++; $display("FAIL b2b_win[%0d] got=%b/%b%b exp=%b/%b%b", i, wd[i], wf[i], wl[i], exp_d[i], exp_f[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_pad_one;
        logic [5:0] exp_d [3] = '{6'b110010, 6'b101101, 6'b011111};
        sel = 1'b1; stall_req = 0;
        load_row(A, B, C);
        run(3, 40);
        sel = 1'b0;
        checks++; if (wd.size() !== 3) begin failures++; $display("FAIL pad1_count got=%0d exp=3", wd.size()); end
        for (int i = 0; i < 3 && i < wd.size(); i++) begin
            checks++; if (wd[i] !== exp_d[i]) begin failures++; $display("FAIL pad1_data[%0d] got=%b exp=%b", i, wd[i], exp_d[i]); end
        end
    endtask

    task automatic test_flush;
        logic [5:0] exp_d [3] = '{6'b011111, 6'b111111, 6'b111110};
        bit         exp_f [3] = '{1'b1, 1'b0, 1'b0};
        bit         exp_l [3] = '{1'b0, 1'b0, 1'b1};
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = A;
        @(negedge clk);
        in_data = B;
        @(negedge clk);
        // Window 0 of the old row is now pending; flush while it is offered.
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        #1;
        checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%b exp=1", ov0); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", ov0); end
        checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", ir0); end
        checks++; if ({of0, ol0} !== 2'b00) begin failures++; $display("FAIL flush_flags got=%b exp=00", {of0, ol0}); end
        sel = 1'b0; stall_req = 0;
        load_row(C, C, C);
        run(3, 40);
        checks++; if (wd.size() !== 3) begin failures++; $display("FAIL flush_count got=%0d exp=3", wd.size()); end
        for (int i = 0; i < 3 && i < wd.size(); i++) begin
            checks++; if ({wd[i], wf[i], wl[i]} !== {exp_d[i], exp_f[i], exp_l[i]}) begin
                failures++; $display("FAIL flush_win[%0d] got=%b/%b%b exp=%b/%b%b", i, wd[i], wf[i], wl[i], exp_d[i], exp_f[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_async_clear;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = A;
        @(negedge clk);
        in_data = B;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL clr_pre_valid got=%b exp=1", ov0); end
        #2;
        clear = 1'b1;
        #1;
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL clr_out_valid got=%b exp=0", ov0); end
        checks++; if (od0 !== 6'd0) begin failures++; $display("FAIL clr_out_data got=%b exp=000000", od0); end
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL clr_in_ready got=%b exp=1", ir0); end
        sel = 1'b0; stall_req = 0;
        load_row(A, B, C);
        run(1, 20);
        checks++; if (wd.size() !== 1) begin failures++; $display("FAIL clr_count got=%0d exp=1", wd.size()); end
        if (wd.size() > 0) begin
            checks++; if ({wd[0], wf[0]} !== {6'b010010, 1'b1}) begin
                failures++; $display("FAIL clr_first_win got=%b/%b exp=010010/1", wd[0], wf[0]);
            end
        end
    endtask

    initial begin
        nsrc = 0; stall_req = 0; sel = 1'b0; bubbles = 0;
        test_reset();
        test_basic_row();
        test_backpressure();
        test_back_to_back();
        test_pad_one();
        test_flush();
        test_async_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
